counter_reg_arbiter: RTL and testbench

//  Shares the counter block's single register bus (addr 0x0 version, 0x1 start,
//  0x2 write-enable, 0x3 set value, 0x4 count) between two requesters:
//  m0 = JTAG DR bridge (already in clk domain), m1 = on-board host/UART bridge.

---
 rtl/counter_regs_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 20 ++
 rtl/counter_reg_arbiter.sv | 151 +++++++++++++++
 tb/tb_counter_reg_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/counter_regs_pkg.sv
// Shared constants for the counter register block and its bus arbiter:
// register map, version word, timeout defaults and arbiter FSM encoding.
package counter_regs_pkg;

  localparam int AW_DEF      = 4;
  localparam int DW_DEF      = 32;
  localparam int TIMEOUT_DEF = 15;

  localparam logic [3:0] REG_VERSION = 4'h0;
  localparam logic [3:0] REG_START   = 4'h1;
  localparam logic [3:0] REG_WE      = 4'h2;
  localparam logic [3:0] REG_SET     = 4'h3;
  localparam logic [3:0] REG_COUNT   = 4'h4;

  localparam logic [31:0] VERSION  = 32'h2012_0911;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// the requester that was not granted last time. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // one-hot grant selection
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/counter_reg_arbiter.sv
// Shares the counter register bus between the JTAG bridge (m0) and the host
// bridge (m1): round-robin, one outstanding transaction, slave-ack timeout.
module counter_reg_arbiter
  import counter_regs_pkg::*;
#(
  parameter int              AW       = AW_DEF,
  parameter int              DW       = DW_DEF,
  parameter int              TIMEOUT  = TIMEOUT_DEF,
  parameter logic [DW-1:0]   ERR_DATA = counter_regs_pkg::ERR_DATA
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic          s_req,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic          s_ack,
  input  logic [DW-1:0] s_rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_e    state_r;
  arb_state_e    state_nxt_s;
  logic [1:0]    gnt_s;
  logic          grant_r;
  logic          last_r;
  logic [TW-1:0] tmo_r;
  logic          done_s;
  logic          timeout_s;

  rr_arb2 u_rr_arb2 (
    .req  ({m1_req, m0_req}),
    .last (last_r),
    .gnt  (gnt_s)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next state; an s_ack outside ISSUE/WAIT is stale and ignored
  always_comb begin
    state_nxt_s = state_r;
    done_s      = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|gnt_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (s_ack) begin
          state_nxt_s = ST_RESP;
          done_s      = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (s_ack) begin
          state_nxt_s = ST_RESP;
          done_s      = 1'b1;
        end else if (tmo_r == TW'(TIMEOUT - 1)) begin
          state_nxt_s = ST_RESP;
          done_s      = 1'b1;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // slave-side issue: latch winner's fields, pulse s_req, run timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_req   <= 1'b0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      grant_r <= 1'b0;
      last_r  <= 1'b1;
      tmo_r   <= '0;
    end else begin
      s_req <= 1'b0;
      if (state_r == ST_IDLE && (|gnt_s)) begin
        s_req   <= 1'b1;
        grant_r <= gnt_s[1];
        s_we    <= gnt_s[1] ? m1_we    : m0_we;
        s_addr  <= gnt_s[1] ? m1_addr  : m0_addr;
        s_wdata <= gnt_s[1] ? m1_wdata : m0_wdata;
        tmo_r   <= '0;
      end else if ((state_r == ST_ISSUE || state_r == ST_WAIT) && tmo_r != {TW{1'b1}}) begin
        tmo_r <= tmo_r + TW'(1);
      end
      if (state_r == ST_RESP) begin
        last_r <= grant_r;
      end
    end
  end

  // requester-side completion; only the winner's outputs change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      if (done_s && !grant_r) begin
        m0_ack   <= 1'b1;
        m0_err   <= timeout_s;
        m0_rdata <= timeout_s ? ERR_DATA : s_rdata;
      end else if (done_s && grant_r) begin
        m1_ack   <= 1'b1;
        m1_err   <= timeout_s;
        m1_rdata <= timeout_s ? ERR_DATA : s_rdata;
      end
    end
  end

endmodule

// File: tb/tb_counter_reg_arbiter.sv
// Bench for counter_reg_arbiter: directed scenarios plus random transactions,
// checked against a transaction-level model of arbitration, latency and timeout.
module tb_counter_reg_arbiter;

  localparam int          TIMEOUT = 15;
  localparam logic [31:0] ERR_W   = 32'hDEAD_BEEF;
  localparam logic [31:0] VER_W   = 32'h2012_0911;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m0_ack, m0_err;
  logic [3:0]  m0_addr = 4'h0;
  logic [31:0] m0_wdata = 32'h0, m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_ack, m1_err;
  logic [3:0]  m1_addr = 4'h0;
  logic [31:0] m1_wdata = 32'h0, m1_rdata;
  logic        s_req, s_we, s_ack = 1'b0;
  logic [3:0]  s_addr;
  logic [31:0] s_wdata, s_rdata = 32'h0;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_gnt = 1;
  logic [31:0] exp_rd [2] = '{32'h0, 32'h0};
  logic        exp_err [2] = '{1'b0, 1'b0};

  counter_reg_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_s_req"}, s_req, 1'b0);
    chk({tag, "_m0_ack"}, m0_ack, 1'b0);
    chk({tag, "_m1_ack"}, m1_ack, 1'b0);
    chk({tag, "_m0_rdata"}, m0_rdata, exp_rd[0]);
    chk({tag, "_m1_rdata"}, m1_rdata, exp_rd[1]);
    chk({tag, "_m0_err"}, m0_err, exp_err[0]);
    chk({tag, "_m1_err"}, m1_err, exp_err[1]);
  endtask

  // Runs one request burst to completion. dX = slave ack delay in cycles after
  // s_req (0 = same cycle); anything outside 0..TIMEOUT-1 means the slave stays silent.
  task automatic serve(input logic r0, input logic r1,
                       input logic we0, input logic [3:0] a0, input logic [31:0] wd0,
                       input logic we1, input logic [3:0] a1, input logic [31:0] wd1,
                       input int d0, input int d1);
    logic        pend [2];
    logic        fw [2];
    logic [3:0]  fa [2];
    logic [31:0] fd [2];
    int          dl [2];
    int          win = 0, s_cyc = 0, exp_ack = -1, exp_issue = 1;
    bit          busy = 1'b0, e_iss, e0, e1, answered;
    logic [31:0] sd = 32'h0;
    pend = '{r0, r1}; fw = '{we0, we1}; fa = '{a0, a1}; fd = '{wd0, wd1}; dl = '{d0, d1};
    m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = wd0;
    m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = wd1;
    for (int t = 0; t < 200 && (pend[0] || pend[1]); t++) begin
      e_iss = !busy && (t == exp_issue);
      chk("s_req", s_req, e_iss);
      if (e_iss) begin
        win = (pend[0] && pend[1]) ? ((last_gnt == 0) ? 1 : 0) : (pend[0] ? 0 : 1);
        chk("s_we", s_we, fw[win]);
        chk("s_addr", s_addr, fa[win]);
        chk("s_wdata", s_wdata, fd[win]);
        busy = 1'b1;
        s_cyc = t;
        answered = (dl[win] >= 0) && (dl[win] <= TIMEOUT - 1);
        exp_ack = t + (answered ? dl[win] + 1 : TIMEOUT);
        sd = (fa[win] == 4'h0 && !fw[win]) ? VER_W : $urandom;
      end
      e0 = busy && (win == 0) && (t == exp_ack);
      e1 = busy && (win == 1) && (t == exp_ack);
      chk("m0_ack", m0_ack, e0);
      chk("m1_ack", m1_ack, e1);
      if (e0 || e1) begin
        exp_rd[win]  = answered ? sd : ERR_W;
        exp_err[win] = !answered;
        chk("m0_rdata", m0_rdata, exp_rd[0]);
        chk("m1_rdata", m1_rdata, exp_rd[1]);
        chk("m0_err", m0_err, exp_err[0]);
        chk("m1_err", m1_err, exp_err[1]);
        pend[win] = 1'b0;
        last_gnt  = win;
        busy      = 1'b0;
        exp_issue = t + 2;
        if (win == 0) m0_req = 1'b0;
        else          m1_req = 1'b0;
      end
      s_ack   = busy && answered && (t == s_cyc + dl[win]);
      s_rdata = s_ack ? sd : $urandom;
      @(posedge clk); #1;
    end
    chk("serve_done", {pend[0], pend[1]}, 2'b00);
    s_ack = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  initial begin
    int r, d0, d1;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_outputs("rst");
    chk("rst_s_we", s_we, 1'b0);
    chk("rst_s_addr", s_addr, 4'h0);
    chk("rst_s_wdata", s_wdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // tie after reset: m0 then m1; next tie goes to m0 again
    serve(1'b1, 1'b1, 1'b0, 4'h4, 32'h0, 1'b1, 4'h1, 32'h1, 2, 0);
    serve(1'b1, 1'b1, 1'b1, 4'h2, 32'h5, 1'b0, 4'h4, 32'h0, 0, 3);
    // m0 reads version, slave acks one cycle after s_req
    serve(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1, 0);
    // m1 write with silent slave -> timeout, then a normal transaction
    serve(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 4'h3, 32'h0000_0100, 0, -1);
    serve(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h4, 32'h0, 0, 2);
    // ack exactly on the timeout cycle wins
    serve(1'b1, 1'b0, 1'b0, 4'h4, 32'h0, 1'b0, 4'h0, 32'h0, TIMEOUT - 1, 0);

    // random traffic
    for (int i = 0; i < 25; i++) begin
      r  = $urandom_range(1, 3);
      d0 = $urandom_range(0, TIMEOUT + 3) - 1;
      d1 = $urandom_range(0, TIMEOUT + 3) - 1;
      serve(r[0], r[1],
            1'($urandom), 4'($urandom_range(0, 4)), $urandom,
            1'($urandom), 4'($urandom_range(0, 4)), $urandom, d0, d1);
    end

    // stray s_ack while idle changes nothing
    s_ack = 1'b1;
    s_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    s_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_outputs("stray");
      @(posedge clk); #1;
    end
    serve(1'b1, 1'b1, 1'b0, 4'h4, 32'h0, 1'b0, 4'h0, 32'h0, 1, 1);

    // reset during WAIT: outputs clear at once, no ack afterwards
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 4'h2; m1_wdata = 32'hABCD_0001;
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    exp_rd  = '{32'h0, 32'h0};
    exp_err = '{1'b0, 1'b0};
    chk_outputs("mid_rst");
    chk("mid_rst_s_we", s_we, 1'b0);
    chk("mid_rst_s_addr", s_addr, 4'h0);
    chk("mid_rst_s_wdata", s_wdata, 32'h0);
    m1_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_gnt = 1;
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      chk_outputs("post_rst");
      @(posedge clk); #1;
    end
    serve(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h4, 32'h0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
